eth_txsched: RTL and testbench
==============================

// Module: eth_txsched
// PURPOSE
//  Packet-granular weighted round-robin scheduler: drains NUM_PORTS first-word-fall-through (FWFT) 74-bit Ethernet word FIFOs into one TX FIFO.
//  Sits ahead of the MAC TX FIFO; per-port packet counters for status regs.
//  Word format (eth_pkg): [73:10] tdata, [9:2] tkeep, [1] tlast, [0] tuser (carried opaquely).
// PARAMETERS
//  NUM_PORTS  4   requester FIFOs, 2..8
//  WEIGHT_W   4   width of per-port weight (packets per turn)
//  CNT_W      32  width of per-port packet counters
// PORTS
//  clk           in   1                clock; all logic single clock domain
//  rst_n         in   1                synchronous, active-low reset
//  in_dout       in   NUM_PORTS*74     FWFT head word, port p at [p*74 +: 74]
//  in_empty      in   NUM_PORTS        per-port FIFO empty
//  in_rd_en      out  NUM_PORTS        per-port pop, at most one bit set
//  out_din       out  74               word to TX FIFO
//  out_wr_en     out  1                write strobe
//  out_afull     in   1                TX FIFO almost-full, >=2 free entries when low
//  cfg_weight    in   NUM_PORTS*WEIGHT_W  packets per turn; 0 treated as 1; sampled at turn start
//  stat_pkt_cnt  out  NUM_PORTS*CNT_W  packets forwarded per port, wraps
//  grant_id      out  3                current/last granted port
//  busy          out  1                high in XFER
// BEHAVIOUR
//  Reset values (rst_n=0 at posedge):
//   in_rd_en=0, out_wr_en=0, out_din=0, stat_pkt_cnt=0, grant_id=0, busy=0, state=IDLE.
//   RR pointer=NUM_PORTS-1, so port 0 has first priority. Reset mid-packet aborts; the downstream sees a truncated packet. No recovery.
//  Handshake:
//   in_rd_en[p] = (state==XFER) && grant==p && !in_empty[p] && !out_afull; combinational.
//   out_din and out_wr_en are registered copies of the popped word/strobe: 1-cycle latency, no bubbles when the source is ready.
//  FSM:
//   IDLE: choose first non-empty port after the RR pointer, with wrap.
//    Load quota=max(cfg_weight[p],1) and set grant; go to XFER the next cycle. No non-empty port: stay in IDLE.
//   XFER: pop while allowed. Popping a word with tlast=1: stat_pkt_cnt[p]++ and quota--.
//    If quota now 0 or in_empty[p] is seen after tlast: RR pointer=p, go to IDLE. Otherwise stay on p for the next packet (same turn).
//   Mid-packet in_empty or out_afull: stall in XFER, hold grant, no timeout, never switch ports mid-packet.
//  Boundaries:
//   Single-word packet (tlast on first word) is legal.
//   Simultaneous requests resolve by RR order only.
//   Counters wrap 2^CNT_W-1 -> 0.
//   cfg_weight changes mid-turn have no effect until the next turn.
//   Minimum IDLE gap is 1 cycle between turns. The back-to-back packets within a turn have 0 gap.
// STRUCTURE
//  eth_pkg holds ETH_WORD_W=74, ETH_LAST_BIT=1, and typedef eth_word_t (packed struct data/keep/last/user).
//   The state enum {IDLE,XFER} is local.
//  Sub-module eth_rr_pick: combinational NUM_PORTS-wide round-robin picker.
//   Inputs: req and pointer. Outputs: valid and idx.
// TESTING
//  1. Port0 only, 3 pkts of 4 words, weight 1 -> 12 out words in order, 3 turns, stat_pkt_cnt[0]=3.
//  2. All 4 ports one 2-word pkt each at t0, weights 1 -> grant order 0,1,2,3, stat cnt 1 each.
//  3. Port0 weight 3, port1 weight 1, both saturated -> out pkt order 0,0,0,1,0,0,0,1.
//  4. out_afull held 5 cycles mid-packet -> no rd_en for those cycles, no word lost or duplicated.
//  5. in_empty mid-packet on granted port while other ports wait -> grant held, resumes on same port.
//  6. rst_n low 1 cycle mid-XFER -> all outputs at reset values next cycle, next grant port 0; also counter wrap with CNT_W=4.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet word definitions for the TX scheduler slice.
// A word is 64b data, 8b byte-keep, end-of-packet flag and an opaque user bit.
package eth_pkg;

  localparam int ETH_WORD_W   = 74;
  localparam int ETH_DATA_W   = 64;
  localparam int ETH_KEEP_W   = 8;
  localparam int ETH_LAST_BIT = 1;

  typedef struct packed {
    logic [ETH_DATA_W-1:0] data;
    logic [ETH_KEEP_W-1:0] keep;
    logic                  last;
    logic                  user;
  } eth_word_t;

endpackage

// File: rtl/eth_txsched_if.sv
// FIFO-side bundle of the scheduler: requester FWFT heads/pops and the TX FIFO write port.
// master is the scheduler, slave is the FIFO environment around it.
interface eth_txsched_if #(
  parameter int NUM_PORTS = 4
);
  import eth_pkg::*;

  logic [NUM_PORTS*ETH_WORD_W-1:0] in_dout;
  logic [NUM_PORTS-1:0]            in_empty;
  logic [NUM_PORTS-1:0]            in_rd_en;
  logic [ETH_WORD_W-1:0]           out_din;
  logic                            out_wr_en;
  logic                            out_afull;

  modport master (
    input  in_dout,
    input  in_empty,
    input  out_afull,
    output in_rd_en,
    output out_din,
    output out_wr_en
  );

  modport slave (
    output in_dout,
    output in_empty,
    output out_afull,
    input  in_rd_en,
    input  out_din,
    input  out_wr_en
  );

endinterface

// File: rtl/eth_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
// ptr = NUM_PORTS-1 gives port 0 the first look.
module eth_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 3
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 valid,
  output logic [IDX_W-1:0]     idx
);

  logic [NUM_PORTS-1:0] req_rot;
  int                   sum;

  // Rotate so bit 0 is the port after ptr, then take the lowest set bit.
  always_comb begin
    req_rot = NUM_PORTS'({req, req} >> (int'(ptr) + 1));
    valid   = 1'b0;
    sum     = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        valid = 1'b1;
        sum   = int'(ptr) + 1 + i;
      end else begin
        valid = valid;
      end
    end
    if (sum >= NUM_PORTS) begin
      sum = sum - NUM_PORTS;
    end else begin
      sum = sum;
    end
    idx = IDX_W'(sum);
  end

endmodule

// File: rtl/eth_txsched_chk.sv
// Handshake invariants of the scheduler's FIFO side, observed every clock.
module eth_txsched_chk #(
  parameter int NUM_PORTS = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic [NUM_PORTS-1:0] in_rd_en,
  input logic [NUM_PORTS-1:0] in_empty,
  input logic                 out_afull
);

  // At most one pop, never from an empty FIFO, never into a nearly full TX FIFO.
  always @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(in_rd_en));
      assert (!(out_afull && (|in_rd_en)));
      assert ((in_rd_en & in_empty) == {NUM_PORTS{1'b0}});
    end
  end

endmodule

// File: rtl/eth_txsched.sv
// Packet-granular weighted round-robin scheduler: drains NUM_PORTS FWFT word FIFOs
// into one TX FIFO, counting forwarded packets per port.
module eth_txsched
  import eth_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int WEIGHT_W  = 4,
  parameter int CNT_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  eth_txsched_if.master                 bus,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] cfg_weight,
  output logic [NUM_PORTS*CNT_W-1:0]    stat_pkt_cnt,
  output logic [2:0]                    grant_id,
  output logic                          busy
);

  localparam int IDX_W = 3;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t               state_r, state_s;
  logic [IDX_W-1:0]     grant_r, grant_s;
  logic [IDX_W-1:0]     ptr_r, ptr_s;
  logic [WEIGHT_W-1:0]  quota_r, quota_s;
  logic                 last_seen_r, last_seen_s;
  logic [CNT_W-1:0]     cnt_r [NUM_PORTS];
  eth_word_t            out_din_r;
  logic                 out_wr_en_r;

  logic [NUM_PORTS-1:0] req_s;
  logic                 pick_valid_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic [WEIGHT_W-1:0]  weight_sel_s;
  logic [NUM_PORTS-1:0] rd_en_s;
  logic                 head_empty_s;
  logic                 pop_s;
  logic                 pop_last_s;
  eth_word_t            pop_word_s;

  assign req_s = ~bus.in_empty;

  eth_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req   (req_s),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Granted port's head word, empty flag and pop strobe.
  always_comb begin
    rd_en_s      = {NUM_PORTS{1'b0}};
    head_empty_s = 1'b1;
    pop_word_s   = {ETH_WORD_W{1'b0}};
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_r == IDX_W'(p)) begin
        head_empty_s = bus.in_empty[p];
        pop_word_s   = bus.in_dout[p*ETH_WORD_W +: ETH_WORD_W];
        rd_en_s[p]   = (state_r == XFER) && !bus.in_empty[p] && !bus.out_afull;
      end else begin
        rd_en_s[p]   = 1'b0;
      end
    end
    pop_s      = |rd_en_s;
    pop_last_s = pop_s && pop_word_s.last;
  end

  // Weight of the port about to be granted; only looked at in IDLE.
  always_comb begin
    weight_sel_s = {WEIGHT_W{1'b0}};
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pick_idx_s == IDX_W'(p)) begin
        weight_sel_s = cfg_weight[p*WEIGHT_W +: WEIGHT_W];
      end else begin
        weight_sel_s = weight_sel_s;
      end
    end
  end

  // Turn control. last_seen_r marks a packet boundary, where an empty FIFO ends the turn.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    ptr_s       = ptr_r;
    quota_s     = quota_r;
    last_seen_s = last_seen_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_s     = XFER;
          grant_s     = pick_idx_s;
          quota_s     = (weight_sel_s == {WEIGHT_W{1'b0}}) ? WEIGHT_W'(1) : weight_sel_s;
          last_seen_s = 1'b0;
        end else begin
          state_s     = IDLE;
        end
      end
      XFER: begin
        if (pop_last_s) begin
          quota_s     = quota_r - WEIGHT_W'(1);
          last_seen_s = 1'b1;
          if (quota_r == WEIGHT_W'(1)) begin
            state_s = IDLE;
            ptr_s   = grant_r;
          end else begin
            state_s = XFER;
          end
        end else if (pop_s) begin
          last_seen_s = 1'b0;
        end else if (last_seen_r && head_empty_s) begin
          state_s = IDLE;
          ptr_s   = grant_r;
        end else begin
          state_s = XFER;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM and turn registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      grant_r     <= {IDX_W{1'b0}};
      ptr_r       <= IDX_W'(NUM_PORTS - 1);
      quota_r     <= {WEIGHT_W{1'b0}};
      last_seen_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      grant_r     <= grant_s;
      ptr_r       <= ptr_s;
      quota_r     <= quota_s;
      last_seen_r <= last_seen_s;
    end
  end

  // Per-port packet counters, free-running with wrap.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!rst_n) begin
        cnt_r[p] <= {CNT_W{1'b0}};
      end else if (pop_last_s && (grant_r == IDX_W'(p))) begin
        cnt_r[p] <= cnt_r[p] + CNT_W'(1);
      end else begin
        cnt_r[p] <= cnt_r[p];
      end
    end
  end

  // One-cycle registered copy of the popped word towards the TX FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_din_r   <= {ETH_WORD_W{1'b0}};
      out_wr_en_r <= 1'b0;
    end else begin
      out_din_r   <= pop_s ? pop_word_s : out_din_r;
      out_wr_en_r <= pop_s;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat
    assign stat_pkt_cnt[g*CNT_W +: CNT_W] = cnt_r[g];
  end

  assign bus.in_rd_en  = rd_en_s;
  assign bus.out_din   = out_din_r;
  assign bus.out_wr_en = out_wr_en_r;
  assign grant_id      = grant_r;
  assign busy          = (state_r == XFER);

  eth_txsched_chk #(
    .NUM_PORTS (NUM_PORTS)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_rd_en  (rd_en_s),
    .in_empty  (bus.in_empty),
    .out_afull (bus.out_afull)
  );

endmodule

// File: tb/tb_eth_txsched.sv
// Randomized bench for eth_txsched: FIFO queues feed the DUT, a packet-level WRR model
// predicts the output word stream; a CNT_W=4 twin on the same inputs exercises counter wrap.
module tb_eth_txsched;
  import eth_pkg::*;

  localparam int NP = 4;
  localparam int WW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  eth_txsched_if #(.NUM_PORTS(NP)) bus ();
  eth_txsched_if #(.NUM_PORTS(NP)) bus_n ();

  logic [NP*74-1:0] in_dout_v;
  logic [NP-1:0]    in_empty_v;
  logic             afull_v;
  logic [NP*WW-1:0] cfg_weight;
  logic [NP*32-1:0] stat_w;
  logic [NP*4-1:0]  stat_n;
  logic [2:0]       grant_id, grant_id_n;
  logic             busy, busy_n;

  assign bus.in_dout     = in_dout_v;
  assign bus.in_empty    = in_empty_v;
  assign bus.out_afull   = afull_v;
  assign bus_n.in_dout   = in_dout_v;
  assign bus_n.in_empty  = in_empty_v;
  assign bus_n.out_afull = afull_v;

  eth_txsched #(.NUM_PORTS(NP), .WEIGHT_W(WW), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cfg_weight(cfg_weight),
    .stat_pkt_cnt(stat_w), .grant_id(grant_id), .busy(busy));

  eth_txsched #(.NUM_PORTS(NP), .WEIGHT_W(WW), .CNT_W(4)) dut_n (
    .clk(clk), .rst_n(rst_n), .bus(bus_n), .cfg_weight(cfg_weight),
    .stat_pkt_cnt(stat_n), .grant_id(grant_id_n), .busy(busy_n));

  logic [73:0] fifo_q [NP][$];
  logic [73:0] mdl_q  [NP][$];
  logic [73:0] exp_q  [$];
  int          mdl_np  [NP];
  int          exp_cnt [NP];
  int          mdl_ptr;
  bit          at_bnd [NP];
  bit          hold   [NP];
  int          n_checks, n_errors, pkt_seq;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_w(input int a, input int b, input int c, input int d);
    cfg_weight = {4'(d), 4'(c), 4'(b), 4'(a)};
  endtask

  task automatic add_pkt(input int p, input int nw);
    logic [73:0] w;
    for (int i = 0; i < nw; i++) begin
      w[73:10] = {8'(p), 16'(pkt_seq), 8'(i), $urandom()};
      w[9:2]   = 8'($urandom());
      w[1]     = (i == nw - 1);
      w[0]     = 1'($urandom());
      fifo_q[p].push_back(w);
      mdl_q[p].push_back(w);
    end
    mdl_np[p]++;
    pkt_seq++;
  endtask

  // WRR over whole packets: next backlogged port after ptr sends min(max(w,1), backlog).
  task automatic build_expected();
    int found, c, w, n;
    logic [73:0] x;
    forever begin
      found = -1;
      for (int k = 1; k <= NP; k++) begin
        c = (mdl_ptr + k) % NP;
        if (found < 0 && mdl_np[c] > 0) found = c;
      end
      if (found < 0) break;
      w = int'(cfg_weight[found*WW +: WW]);
      if (w == 0) w = 1;
      n = (w < mdl_np[found]) ? w : mdl_np[found];
      for (int i = 0; i < n; i++) begin
        do begin
          x = mdl_q[found].pop_front();
          exp_q.push_back(x);
        end while (!x[1]);
        mdl_np[found]--;
        exp_cnt[found]++;
      end
      mdl_ptr = found;
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (fifo_q[p].size() > 0) begin
        in_dout_v[p*74 +: 74] = fifo_q[p][0];
        in_empty_v[p]         = hold[p];
      end else begin
        in_dout_v[p*74 +: 74] = 74'd0;
        in_empty_v[p]         = 1'b1;
      end
    end
  endtask

  task automatic flush_model();
    for (int p = 0; p < NP; p++) begin
      fifo_q[p].delete();
      mdl_q[p].delete();
      mdl_np[p]  = 0;
      exp_cnt[p] = 0;
      at_bnd[p]  = 1'b1;
      hold[p]    = 1'b0;
    end
    exp_q.delete();
    mdl_ptr = NP - 1;
    afull_v = 1'b0;
    drive();
  endtask

  task automatic check_reset_outputs();
    chk("rst_rd_en", bus.in_rd_en, 0);
    chk("rst_wr_en", bus.out_wr_en, 0);
    chk("rst_din", bus.out_din, 0);
    chk("rst_cnt", stat_w, 0);
    chk("rst_cnt_n", stat_n, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic check_counts();
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("cnt%0d", p), stat_w[p*32 +: 32], exp_cnt[p]);
      chk($sformatf("cnt_wrap%0d", p), stat_n[p*4 +: 4], exp_cnt[p] % 16);
    end
  endtask

  // One scenario: -1 disables afull_at / reset_at / chg_w.
  task automatic run_scenario(input bit rand_on, input int afull_at, input int reset_at, input int chg_w);
    int cyc, idle_cyc, pp, af_left;
    bit done, chg_done;
    logic [NP-1:0] rd;
    logic [73:0] w, e;
    cyc = 0; idle_cyc = 0; af_left = 0; done = 1'b0; chg_done = 1'b0;
    drive();
    while (!done) begin
      @(negedge clk);
      if (cyc == reset_at) rst_n = 1'b0;
      rd = bus.in_rd_en;
      chk("rd_legal", $onehot0(rd) && ((rd & in_empty_v) == '0), 1);
      if (afull_v) chk("afull_stall", rd, 0);
      @(posedge clk);
      #1;
      pp = -1;
      for (int p = 0; p < NP; p++) if (rd[p]) pp = p;
      if (pp >= 0) begin
        w = fifo_q[pp].pop_front();
        at_bnd[pp] = w[1];
      end
      if (cyc == reset_at) begin
        rst_n = 1'b1;
        check_reset_outputs();
        flush_model();
        done = 1'b1;
      end else begin
        if (bus.out_wr_en) begin
          if (exp_q.size() == 0) begin
            chk("extra_word", bus.out_wr_en, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_din", bus.out_din, e);
            chk("grant_id", grant_id, e[73:66]);
          end
        end
        if (chg_w >= 0 && !chg_done && busy) begin
          cfg_weight[WW-1:0] = WW'(chg_w);
          chg_done = 1'b1;
        end
        if (cyc == afull_at) af_left = 5;
        if (af_left > 0) begin
          afull_v = 1'b1;
          af_left--;
        end else begin
          afull_v = rand_on && ($urandom_range(0, 3) == 0);
        end
        for (int p = 0; p < NP; p++)
          hold[p] = rand_on && !at_bnd[p] && ($urandom_range(0, 3) == 0);
        drive();
        if (exp_q.size() == 0 && !busy) idle_cyc++;
        else idle_cyc = 0;
        if (idle_cyc >= 3) done = 1'b1;
        cyc++;
        if (!done && cyc > 4000) begin
          chk("timeout", cyc, 0);
          done = 1'b1;
        end
      end
    end
    if (reset_at < 0) begin
      chk("exp_drained", exp_q.size(), 0);
      afull_v = 1'b0;
      drive();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    flush_model();
  endtask

  initial begin
    n_checks = 0; n_errors = 0; pkt_seq = 0;
    in_dout_v = '0; in_empty_v = '1; afull_v = 1'b0;
    set_w(1, 1, 1, 1);
    flush_model();
    do_reset();

    // Port 0 alone, three 4-word packets, weight 1.
    for (int i = 0; i < 3; i++) add_pkt(0, 4);
    build_expected();
    run_scenario(1'b0, -1, -1, -1);
    check_counts();

    // All ports one 2-word packet from reset: order 0,1,2,3.
    do_reset();
    for (int p = 0; p < NP; p++) add_pkt(p, 2);
    build_expected();
    run_scenario(1'b0, -1, -1, -1);
    check_counts();

    // Weights 3 and 1, both saturated.
    set_w(3, 1, 1, 1);
    for (int i = 0; i < 6; i++) add_pkt(0, $urandom_range(1, 5));
    for (int i = 0; i < 2; i++) add_pkt(1, $urandom_range(1, 5));
    build_expected();
    run_scenario(1'b0, -1, -1, -1);
    check_counts();

    // TX FIFO almost-full for 5 cycles in mid-packet.
    set_w(1, 1, 2, 1);
    add_pkt(2, 8); add_pkt(2, 8); add_pkt(3, 6);
    build_expected();
    run_scenario(1'b0, 4, -1, -1);
    check_counts();

    // Granted FIFO runs dry mid-packet while others wait.
    set_w(2, 1, 3, 0);
    for (int p = 0; p < NP; p++) begin
      add_pkt(p, $urandom_range(3, 7));
      add_pkt(p, $urandom_range(1, 7));
    end
    build_expected();
    run_scenario(1'b1, -1, -1, -1);
    check_counts();

    // Port 0 weight lowered after its turn has begun.
    set_w(2, 1, 1, 1);
    add_pkt(0, 3); add_pkt(0, 2); add_pkt(1, 2); add_pkt(1, 3);
    build_expected();
    run_scenario(1'b0, -1, -1, 1);
    check_counts();

    // 18 single-word packets on port 2: two turns and a 4-bit counter wrap.
    set_w(1, 1, 15, 1);
    for (int i = 0; i < 18; i++) add_pkt(2, 1);
    build_expected();
    run_scenario(1'b1, -1, -1, -1);
    check_counts();

    for (int s = 0; s < 5; s++) begin
      set_w($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      for (int p = 0; p < NP; p++) begin
        int np;
        np = $urandom_range(0, 4);
        for (int i = 0; i < np; i++) add_pkt(p, $urandom_range(1, 6));
      end
      build_expected();
      run_scenario(1'b1, -1, -1, -1);
      check_counts();
    end

    // Reset pulse mid-transfer, then a fresh round must start at port 0.
    set_w(1, 1, 1, 1);
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < 3; i++) add_pkt(p, 4);
    build_expected();
    run_scenario(1'b1, -1, 12, -1);
    for (int p = NP - 1; p >= 0; p--) add_pkt(p, 2);
    build_expected();
    run_scenario(1'b0, -1, -1, -1);
    check_counts();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
